// File: rtl/opb_register_simulink2ppc.sv
// OPB slave register bank for the fabric-to-PPC direction.
// The fabric pushes a 32-bit word with a strobe. The PPC reads back the
// latched word, or a status word that holds the new-data flag, the overrun
// flag and a 16-bit update count.
module opb_register_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_new_data,
    output logic                    user_read_ack
);

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

    localparam logic [1:0] SEL_DATA   = 2'b00;
    localparam logic [1:0] SEL_STATUS = 2'b01;

    state_t      state;
    logic [31:0] data_reg;
    logic        new_data;
    logic        overrun;
    logic [15:0] update_count;

    // Transfer attributes captured at the hit. Side effects use them in ACK.
    logic        acc_read;
    logic [1:0]  acc_sel;
    logic        acc_be3;
    logic [1:0]  acc_w1c;

    logic        hit;
    logic [1:0]  sel;
    logic [31:0] addr_off;
    logic [31:0] rd_mux;
    logic        data_rd_ack;
    logic        status_wr;
    logic        clr_new;
    logic        clr_ovr;

    // Unsigned offset compare. It covers BASE <= addr <= HIGH without a
    // constant-folded ">= 0" when the base is zero.
    assign addr_off = OPB_ABus - C_BASEADDR;
    assign hit      = OPB_select && (addr_off <= (C_HIGHADDR - C_BASEADDR));
    // Big-endian bits 28:29 are the word offset (LSB byte-address bits 3:2).
    assign sel      = OPB_ABus[28:29];

    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_new_data = new_data;

    // Read mux over the current register state. It is registered at the hit.
    always_comb begin
        rd_mux = 32'h0;
        case (sel)
            SEL_DATA:   rd_mux = data_reg;
            SEL_STATUS: rd_mux = {update_count, 14'h0, overrun, new_data};
            default:    rd_mux = 32'h0;
        endcase
    end

    // Side-effect qualifiers, which are only live during the ACK cycle.
    assign data_rd_ack = (state == ACK) && acc_read && (acc_sel == SEL_DATA);
    assign status_wr   = (state == ACK) && !acc_read && (acc_sel == SEL_STATUS) && acc_be3;
    assign clr_new     = data_rd_ack || (status_wr && acc_w1c[0]);
    assign clr_ovr     = status_wr && acc_w1c[1];

    // Bus FSM. It gives one ack per select assertion and registers all bus outputs.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state         <= IDLE;
            Sl_xferAck    <= 1'b0;
            Sl_DBus       <= '0;
            user_read_ack <= 1'b0;
            acc_read      <= 1'b0;
            acc_sel       <= 2'b00;
            acc_be3       <= 1'b0;
            acc_w1c       <= 2'b00;
        end else begin
            Sl_xferAck    <= 1'b0;
            Sl_DBus       <= '0;
            user_read_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        state         <= ACK;
                        Sl_xferAck    <= 1'b1;
                        // A packed assignment maps user bit i to OPB bit 31-i.
                        Sl_DBus       <= OPB_RNW ? rd_mux : 32'h0;
                        user_read_ack <= OPB_RNW && (sel == SEL_DATA);
                        acc_read      <= OPB_RNW;
                        acc_sel       <= sel;
                        acc_be3       <= OPB_BE[3];
                        acc_w1c       <= {OPB_DBus[30], OPB_DBus[31]};
                    end
                end
                ACK:     state <= WAIT;
                WAIT:    if (!OPB_select) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register bank. A fabric set beats a bus clear, and a fresh overrun beats a W1C.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            data_reg     <= 32'h0;
            new_data     <= 1'b0;
            overrun      <= 1'b0;
            update_count <= 16'h0;
        end else begin
            if (user_data_valid) begin
                data_reg     <= user_data_in;
                update_count <= update_count + 16'd1;
            end
            new_data <= user_data_valid || (new_data && !clr_new);
            overrun  <= (user_data_valid && new_data && !clr_new) || (overrun && !clr_ovr);
        end
    end

    // The address, byte enables and data bits not listed here are not decoded.
    logic unused_bits;
    assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29]};

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Testbench for opb_register_simulink2ppc. It drives directed scenarios,
// then random bus and fabric traffic, and checks against a register-level model.
module tb_opb_register_simulink2ppc;

    logic        OPB_Clk = 1'b0;
    logic        OPB_Rst;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
    logic [31:0] user_data_in;
    logic        user_data_valid;
    logic        user_new_data, user_read_ack;

    opb_register_simulink2ppc dut (
        .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
        .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
        .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
        .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
        .user_data_in(user_data_in), .user_data_valid(user_data_valid),
        .user_new_data(user_new_data), .user_read_ack(user_read_ack)
    );

    always #5 OPB_Clk = ~OPB_Clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_data;
    logic        m_nd, m_ov;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] s);
        case (s)
            2'd0:    return m_data;
            2'd1:    return {m_cnt, 14'h0, m_ov, m_nd};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = 0; m_nd = 0; m_ov = 0; m_cnt = 0;
    endtask

    // One clock of register behaviour. Clears apply first, then the fabric write.
    task automatic m_step(input bit rd, input logic [1:0] s, input bit be3,
                          input logic [31:0] wd, input bit v, input logic [31:0] vd);
        bit clr_nd, clr_ov, old_nd;
        clr_nd = 0; clr_ov = 0; old_nd = m_nd;
        if (rd && s == 2'd0) clr_nd = 1;
        if (!rd && s == 2'd1 && be3) begin clr_nd = wd[0]; clr_ov = wd[1]; end
        if (clr_nd) m_nd = 0;
        if (clr_ov) m_ov = 0;
        if (v) begin
            if (old_nd && !clr_nd) m_ov = 1;
            m_nd = 1; m_data = vd; m_cnt = m_cnt + 16'd1;
        end
    endtask

    function automatic logic [31:0] mk_addr(input logic [1:0] s);
        logic [3:0] hi;
        logic [1:0] lo;
        hi = 4'($urandom);
        lo = 2'($urandom);
        return {24'h0, hi, s, lo};
    endfunction

    task automatic do_reset();
        @(negedge OPB_Clk);
        OPB_Rst = 1; OPB_select = 0; user_data_valid = 0;
        @(negedge OPB_Clk);
        @(negedge OPB_Clk);
        OPB_Rst = 0;
        m_reset();
    endtask

    task automatic valid_pulse(input logic [31:0] vd);
        @(negedge OPB_Clk);
        user_data_valid = 1; user_data_in = vd;
        @(negedge OPB_Clk);
        user_data_valid = 0;
        m_step(0, 2'd2, 0, 0, 1, vd);
        chk("valid_new_data", user_new_data, m_nd);
    endtask

    // Full OPB transfer. It can also put a fabric write into the ACK cycle.
    task automatic xfer(input logic [31:0] addr, input bit rd, input logic [3:0] be,
                        input logic [31:0] wd, input bit v, input logic [31:0] vd,
                        output logic [31:0] rdata);
        logic [1:0]  s;
        logic [31:0] exp;
        s   = addr[3:2];
        exp = rd ? m_read(s) : 32'h0;
        @(negedge OPB_Clk);
        OPB_ABus = addr; OPB_RNW = rd; OPB_BE = be; OPB_DBus = wd; OPB_select = 1;
        #1 chk("ack_before_latency", Sl_xferAck, 0);
        @(negedge OPB_Clk);
        chk("ack_cycle", Sl_xferAck, 1);
        chk("read_data", Sl_DBus, exp);
        chk("bit_map_lsb", Sl_DBus[31], exp[0]);
        chk("read_ack_pulse", user_read_ack, (rd && s == 2'd0) ? 1 : 0);
        rdata = Sl_DBus;
        if (v) begin user_data_valid = 1; user_data_in = vd; end
        @(negedge OPB_Clk);
        user_data_valid = 0;
        chk("ack_dropped", Sl_xferAck, 0);
        chk("dbus_zero_after_ack", Sl_DBus, 0);
        chk("read_ack_dropped", user_read_ack, 0);
        OPB_select = 0;
        m_step(rd, s, be[0], wd, v, vd);
        chk("user_new_data", user_new_data, m_nd);
    endtask

    logic [31:0] rd;
    int          acks;
    logic [31:0] last;

    initial begin
        OPB_Rst = 1; OPB_ABus = 0; OPB_BE = 0; OPB_DBus = 0; OPB_RNW = 0;
        OPB_select = 0; OPB_seqAddr = 0; user_data_in = 0; user_data_valid = 0;
        m_reset();

        // Reset state
        do_reset();
        @(negedge OPB_Clk);
        chk("rst_ack", Sl_xferAck, 0);
        chk("rst_dbus", Sl_DBus, 0);
        chk("rst_new_data", user_new_data, 0);
        chk("rst_read_ack", user_read_ack, 0);
        chk("rst_tied", {Sl_errAck, Sl_retry, Sl_toutSup}, 0);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("rst_status", rd, 32'h0);

        // Single update, then DATA read
        valid_pulse(32'h1234_5678);
        xfer(32'h0, 1, 4'hF, 0, 0, 0, rd);
        chk("data_12345678", rd, 32'h1234_5678);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("status_after_read", rd, 32'h0001_0000);

        // Two updates without a read, so the overrun flag sets
        do_reset();
        valid_pulse(32'hA);
        valid_pulse(32'hB);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("status_overrun", rd, 32'h0002_0003);
        xfer(32'h4, 0, 4'b0001, 32'h2, 0, 0, rd);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("status_w1c_ovr", rd, 32'h0002_0001);
        xfer(32'h4, 0, 4'b0000, 32'h3, 0, 0, rd);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("status_be0_ignored", rd, 32'h0002_0001);
        xfer(32'h0, 1, 4'hF, 0, 0, 0, rd);
        chk("data_B", rd, 32'hB);

        // Select held for 5 cycles gives exactly one ack
        @(negedge OPB_Clk);
        OPB_ABus = 32'h4; OPB_RNW = 1; OPB_BE = 4'hF; OPB_select = 1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge OPB_Clk);
            if (Sl_xferAck) begin
                acks++;
                chk("hold_data", Sl_DBus, m_read(2'd1));
            end else begin
                chk("hold_idle_dbus", Sl_DBus, 0);
            end
        end
        OPB_select = 0;
        @(negedge OPB_Clk);
        chk("hold_ack_count", acks, 1);

        // A valid during the ACK of a DATA read
        valid_pulse(32'hB);
        xfer(32'h0, 1, 4'hF, 0, 1, 32'hC, rd);
        chk("coincident_old_value", rd, 32'hB);
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("coincident_status", rd[1:0], 2'b01);
        xfer(32'h0, 1, 4'hF, 0, 0, 0, rd);
        chk("coincident_new_value", rd, 32'hC);

        // Address outside the decoded range gets no ack
        @(negedge OPB_Clk);
        OPB_ABus = 32'h100; OPB_RNW = 1; OPB_select = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge OPB_Clk);
            chk("out_of_range_ack", Sl_xferAck, 0);
        end
        OPB_select = 0;

        // Reset asserted in the ACK cycle
        valid_pulse(32'h5A5A_5A5A);
        @(negedge OPB_Clk);
        OPB_ABus = 32'h0; OPB_RNW = 1; OPB_select = 1;
        @(negedge OPB_Clk);
        chk("pre_rst_ack", Sl_xferAck, 1);
        OPB_Rst = 1;
        @(negedge OPB_Clk);
        chk("rst_in_ack_ack", Sl_xferAck, 0);
        chk("rst_in_ack_dbus", Sl_DBus, 0);
        chk("rst_in_ack_nd", user_new_data, 0);
        chk("rst_in_ack_rack", user_read_ack, 0);
        // Reset together with the hit cycle produces no ack
        @(negedge OPB_Clk);
        chk("rst_with_hit_ack", Sl_xferAck, 0);
        OPB_select = 0;
        @(negedge OPB_Clk);
        OPB_Rst = 0;
        m_reset();
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("rst_in_ack_status", rd, 0);
        xfer(32'h0, 1, 4'hF, 0, 0, 0, rd);
        chk("rst_in_ack_data", rd, 0);

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [31:0] r32;
            logic [1:0]  s;
            r32 = $urandom;
            s   = 2'($urandom);
            case ($urandom_range(0, 5))
                0: valid_pulse(r32);
                1: begin
                    xfer(mk_addr(s), 1, 4'($urandom), 0, 0, 0, rd);
                end
                2: xfer(mk_addr(2'd1), 0, 4'($urandom), {30'($urandom), 2'($urandom)}, 0, 0, rd);
                3: xfer(mk_addr(2'd0), 1, 4'hF, 0, 1, r32, rd);
                4: xfer(mk_addr(2'd1), 0, 4'b0001, {30'h0, 2'($urandom)}, 1, r32, rd);
                default: xfer(mk_addr((s == 2'd1) ? 2'd0 : s), 0, 4'hF, $urandom,
                              1'($urandom), r32, rd);
            endcase
        end
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("random_final_status", rd, m_read(2'd1));

        // 65536 updates from reset wrap the count back to zero
        do_reset();
        for (int i = 0; i < 65536; i++) begin
            @(negedge OPB_Clk);
            last = $urandom;
            user_data_valid = 1; user_data_in = last;
            m_step(0, 2'd2, 0, 0, 1, last);
        end
        @(negedge OPB_Clk);
        user_data_valid = 0;
        xfer(32'h4, 1, 4'hF, 0, 0, 0, rd);
        chk("wrap_status", rd, 32'h0000_0003);
        chk("wrap_model_status", rd, m_read(2'd1));
        xfer(32'h0, 1, 4'hF, 0, 0, 0, rd);
        chk("wrap_data", rd, last);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc.md
Name: opb_register_simulink2ppc

Overview:
- OPB slave register bank for the fabric-to-PowerPC direction. Fabric logic pushes a 32-bit word with a strobe; the PPC reads that word and a status word over OPB.
- Gives firmware a latched value, a new-data flag, an overrun flag and an update count.
- One `darkquad29_*` status/readback register (e.g. a phase-centre readback) is one instance.
- Single clock domain: fabric logic driving `user_*` runs on `OPB_Clk`.

Parameters:
- `C_BASEADDR`, 32'h00000000: first byte address of the block.
- `C_HIGHADDR`, 32'h000000FF: last byte address decoded.
- `C_OPB_AWIDTH`, 32: OPB address width. Only 32 is supported.
- `C_OPB_DWIDTH`, 32: OPB data width. Only 32 is supported.
- `C_FAMILY`, "virtex6": target family. Informational only.

Ports:
- `OPB_Clk` in 1: the only clock.
- `OPB_Rst` in 1: reset, synchronous, active-high.
- `OPB_ABus` in [0:31]: OPB address, big-endian bit numbering.
- `OPB_BE` in [0:3]: byte enables. `OPB_BE[3]` covers `DBus[24:31]`.
- `OPB_DBus` in [0:31]: OPB write data.
- `OPB_RNW` in 1: 1 = read, 0 = write.
- `OPB_select` in 1: transfer request.
- `OPB_seqAddr` in 1: ignored.
- `Sl_DBus` out [0:31]: read data. Zero whenever `Sl_xferAck`=0.
- `Sl_xferAck` out 1: transfer acknowledge, one-cycle pulse.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1 each: tied 0.
- `user_data_in` in [31:0]: word from fabric.
- `user_data_valid` in 1: latch strobe for `user_data_in`.
- `user_new_data` out 1: mirror of `STATUS.new_data`.
- `user_read_ack` out 1: one-cycle pulse when the PPC completes a `DATA` read.

Behaviour:
- Reset (synchronous; applies from any state, including mid-transfer):
  - FSM → IDLE.
  - `data_reg`, `new_data`, `overrun`, `update_count` → 0.
  - All outputs → 0.
  - No acknowledge is issued for a transfer interrupted by reset.
- Bit mapping: user/LSB bit i ↔ OPB bit 31−i on both `DBus` buses.
- Address decode:
  - `hit = OPB_select && C_BASEADDR <= OPB_ABus <= C_HIGHADDR`.
  - Register selected by `OPB_ABus[28:29]`:
    - 00 = `DATA`: read-only; writes are acked and ignored.
    - 01 = `STATUS`.
    - 10 and 11: read 0, writes acked and ignored.
- `STATUS` layout (LSB numbering):
  - bit0 = `new_data`.
  - bit1 = `overrun`.
  - bits 15:2 = 0.
  - bits 31:16 = `update_count`.
- FSM (IDLE, ACK, WAIT):
  - IDLE: on `hit` in cycle N, register the read data from the register state of cycle N, then go to ACK.
  - ACK (cycle N+1): `Sl_xferAck`=1. For reads, `Sl_DBus` = registered data. Write side effects and read side effects commit at the end of this cycle. Go to WAIT.
  - WAIT: stay until `OPB_select`=0, then go to IDLE. This guarantees exactly one ack per select assertion.
- Read latency: 1 cycle from `hit` to ack.
- `DATA` read side effects (at ACK):
  - `new_data` cleared.
  - `user_read_ack` pulses 1 in the ACK cycle.
- `STATUS` write (at ACK): only honoured when `OPB_BE[3]`=1.
  - Write-1-to-clear: LSB bit0 (`OPB_DBus[31]`) clears `new_data`.
  - LSB bit1 (`OPB_DBus[30]`) clears `overrun`.
  - Other bits are ignored.
- `STATUS` read: no side effects.
- `user_data_valid`=1 in cycle M, effective at the next edge:
  - `data_reg` ← `user_data_in`.
  - `new_data` ← 1.
  - `update_count` ← `update_count` + 1, wrapping 16'hFFFF → 0.
  - If `new_data` was 1 and is not being cleared in the same cycle, `overrun` ← 1.
- Simultaneous events:
  - Valid in the ACK cycle of a `DATA` read: the read returns the old value (already registered). Set beats clear, so `new_data` ends at 1. `overrun` is not set.
  - Valid while a `STATUS` W1C of `new_data` is in its ACK cycle: `new_data` ends at 1, no overrun.
  - Valid while a W1C of `overrun` is acked: the clear wins only if no new overrun condition occurs in that cycle. Otherwise `overrun` ends at 1.
- `user_new_data` equals the `new_data` register (registered output, no added latency).

Test Plan:
- Reset, then read `STATUS` → `Sl_DBus`=0, ack exactly 1 cycle after select; `user_new_data`=0.
- Pulse valid with 0x12345678, then read `DATA` → 0x12345678 (`Sl_DBus[31]` = LSB 0), `user_read_ack` pulses once, `STATUS` afterwards = 0x00010000.
- Two valids (0xA, 0xB) with no read → `DATA`=0xB, `STATUS`=0x00020003; write 0x2 with `BE`=0001 → `STATUS`=0x00020001; write with `BE`=0000 → unchanged.
- Hold `OPB_select` high for 5 cycles → exactly one `xferAck`; `Sl_DBus`=0 outside the ack cycle.
- Valid 0xC coincident with the ack of a `DATA` read of 0xB → read returns 0xB, `new_data`=1, `overrun`=0; 65536 valids from reset → `update_count` wraps to 0.
- Assert `OPB_Rst` in the ACK state → no ack, all registers and outputs 0 next cycle; address outside `C_BASEADDR`..`C_HIGHADDR` → no ack.
